// File: rtl/mux_nway_arb_if.sv
// mux_nway_arb_if: bundle of the per-channel request side and the single
// output side of the arbitrated multiplexer.
//   in_data   NUM_IN*WIDTH  channel i data at [i*WIDTH +: WIDTH]
//   in_valid  NUM_IN        per-channel request
//   in_last   NUM_IN        per-channel end-of-packet flag
//   in_ready  NUM_IN        per-channel accept (at most one bit high)
//   out_data  WIDTH         registered selected word
//   out_src   SEL_W         channel that supplied out_data
//   out_last  1             end-of-packet flag of out_data
//   out_valid 1             output word present
//   out_ready 1             consumer accept
// slave  : the multiplexer's view; master : the producer/consumer side.
interface mux_nway_arb_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_src, out_last, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_src, out_last, out_valid
  );
endinterface

// File: rtl/mux_nway_arb.sv
// mux_nway_arb: N-input, WIDTH-bit flow-controlled multiplexer. Picks one
// requesting channel per cycle (forced, fixed-priority or round-robin), holds
// the choice for the length of a packet, and forwards the word through one
// output register.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   mode      00 forced, 01 fixed priority, 10 round-robin, 11 as 01
//   force_sel channel used in forced mode
//   bus       mux_nway_arb_if.slave (channel inputs, registered output)
module mux_nway_arb #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] force_sel,
  mux_nway_arb_if.slave    bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_lock_ch;
  logic [SEL_W-1:0]   w_lock_nxt;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   w_rr_nxt;

  logic [WIDTH-1:0]   r_out_data;
  logic [SEL_W-1:0]   r_out_src;
  logic               r_out_last;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_xfer;
  logic [NUM_IN-1:0]  w_grant;
  logic [NUM_IN-1:0]  w_lock_hit;
  logic [NUM_IN-1:0]  w_force_hit;
  logic [NUM_IN-1:0]  w_rr_hi;
  logic [SEL_W-1:0]   w_gnt_idx;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_sel_last;

  // Isolate the lowest set bit of a request vector.
  function automatic logic [NUM_IN-1:0] lowest_one(input logic [NUM_IN-1:0] v);
    return v & (~v + NUM_IN'(1));
  endfunction

  assign w_accept = ~r_out_valid | bus.out_ready;

  // A shift past NUM_IN-1 yields zero, so an out-of-range force_sel grants nothing.
  assign w_lock_hit  = bus.in_valid & (NUM_IN'(1) << r_lock_ch);
  assign w_force_hit = bus.in_valid & (NUM_IN'(1) << force_sel);
  // Requests at or above the round-robin pointer; fall back to all requests to wrap.
  assign w_rr_hi     = bus.in_valid & ~((NUM_IN'(1) << r_rr_ptr) - NUM_IN'(1));

  // One-hot grant from lock state, mode and requests.
  always_comb begin
    w_grant = '0;
    if (r_state == ST_LOCKED) begin
      w_grant = w_lock_hit;
    end else begin
      case (mode)
        2'b00:   w_grant = w_force_hit;
        2'b10:   w_grant = (w_rr_hi != '0) ? lowest_one(w_rr_hi) : lowest_one(bus.in_valid);
        default: w_grant = lowest_one(bus.in_valid);
      endcase
    end
  end

  // Encode the grant and steer the granted channel's word and last flag.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_gnt_idx  = w_gnt_idx  | (w_grant[i] ? SEL_W'(i) : '0);
      w_sel_data = w_sel_data | (w_grant[i] ? bus.in_data[i*WIDTH +: WIDTH] : '0);
      w_sel_last = w_sel_last | (w_grant[i] & bus.in_last[i]);
    end
  end

  assign w_xfer       = w_accept & (|w_grant);
  assign bus.in_ready = {NUM_IN{reset_n & w_accept}} & w_grant;

  // Packet-lock next state and round-robin pointer advance.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_ch;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && !w_sel_last) begin
          w_state_nxt = ST_LOCKED;
          w_lock_nxt  = w_gnt_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (w_xfer && w_sel_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // The pointer moves on every packet end, whatever the mode, so that a
    // later switch to round-robin starts from a fair position.
    if (w_xfer && w_sel_last) begin
      w_rr_nxt = (w_gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + SEL_W'(1);
    end else begin
      w_rr_nxt = r_rr_ptr;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_nxt;
      r_rr_ptr  <= w_rr_nxt;
    end
  end

  // Output register: load on transfer, drain on accept without transfer, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= w_sel_data;
      r_out_src   <= w_gnt_idx;
      r_out_last  <= w_sel_last;
      r_out_valid <= 1'b1;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_last  = r_out_last;
  assign bus.out_valid = r_out_valid;

endmodule

// File: doc/mux_nway_arb.md
# mux_nway_arb

Parametrised N-input, W-bit registered multiplexer with per-channel valid/ready handshake, selectable arbitration mode and packet lock. Generalises the fixed 3:1 32-bit operand select into a flow-controlled stage: chooses one requesting channel per cycle and forwards its word through one output register. Sits between datapath producers (ALU result, memory read, forwarded operands) and a shared consumer such as the writeback bus.

## Interface
- WIDTH, 32, data width of every channel and of the output
- NUM_IN, 3, number of input channels (2..16)
- SEL_W, 2, width of select/source fields; must satisfy 2^SEL_W >= NUM_IN
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  2  00 forced select, 01 fixed priority, 10 round-robin, 11 treated as 01
- force_sel  in  SEL_W  channel index used in mode 00
- in_data  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_IN  per-channel request
- in_last  in  NUM_IN  per-channel end-of-packet flag, sampled with in_data
- in_ready  out  NUM_IN  per-channel accept; at most one bit high
- out_data  out  WIDTH  registered selected word
- out_src  out  SEL_W  index of channel that supplied out_data
- out_last  out  1  registered in_last of the forwarded word
- out_valid  out  1  output word present
- out_ready  in  1  consumer accept

## Operation
- accept = !out_valid | out_ready. Transfer on channel g when in_valid[g] & in_ready[g].
- in_ready[i] = accept & grant[i]; grant is one-hot or zero, combinational from current state and inputs.
- Grant, state IDLE:
  - mode 00: grant force_sel if force_sel < NUM_IN and in_valid[force_sel]; else none. Never grant another channel.
  - mode 01/11: lowest-indexed valid channel.
  - mode 10: first valid channel searching upward from rr_ptr, wrapping NUM_IN-1 -> 0.
- State machine: IDLE -> LOCKED on a transfer with in_last=0; lock_ch <= g. LOCKED: grant only lock_ch (if valid), ignoring mode and force_sel. LOCKED -> IDLE on a transfer from lock_ch with in_last=1. Transfer with in_last=1 in IDLE stays IDLE.
- rr_ptr updates only on a transfer with in_last=1: rr_ptr <= (g == NUM_IN-1) ? 0 : g+1. Updated in every mode so switching to mode 10 stays fair.
- Output register: on transfer, out_data <= channel g data, out_src <= g, out_last <= in_last[g], out_valid <= 1. If accept & no transfer, out_valid <= 0. If !accept, all output registers hold.
- mode/force_sel change mid-packet: no effect until lock releases.
- in_valid dropped by lock_ch while LOCKED: no grant, lock held, no bubble filled by others.

## Timing
- Reset (reset_n low, asynchronous): out_valid=0, out_data=0, out_src=0, out_last=0, rr_ptr=0, state IDLE, lock_ch=0; in_ready forced to 0 while reset_n low.
- Latency: word accepted at edge N appears on out_data/out_valid after edge N; 1 cycle.
- Throughput: one word per cycle while out_ready=1; out_valid held with out_data stable while out_ready=0.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode, force_sel; no combinational path from in_data to out_data.
- Reset deasserted mid-packet: lock discarded, restart in IDLE.

## Test plan
- Reset: reset_n=0 with all in_valid=1 -> in_ready=000, out_valid=0, out_data=0; release -> first edge loads channel 0 in mode 01.
- Forced select: mode=00, force_sel=2, in_valid=111, data 0xAAAAAAAA/0x55555555/0xFFFFFFFF -> out_data=0xFFFFFFFF, out_src=2; force_sel=3 -> in_ready=000, out_valid falls next cycle.
- Round-robin: mode=10, in_valid=111, in_last=111, out_ready=1 -> out_src sequence 0,1,2,0,1,2 on consecutive cycles.
- Packet lock: mode=10, channel 1 sends 3 beats last=0,0,1 while channels 0,2 valid -> out_src=1,1,1 then 2; force mode=00 mid-packet has no effect.
- Backpressure: out_ready=0 for 4 cycles after out_data=0x12345678 -> out_data/out_valid stable, in_ready=000; out_ready=1 -> next word loads same cycle.
- Priority: mode=01, in_valid=110 -> out_src=1 every cycle; in_valid=111 -> out_src=0.
